sa_cache_data: RTL and testbench
================================

Name: sa_cache_data

Overview:
Parametrised N-way set-associative cache data array. It is the successor of the direct-mapped data store and sits between the cache controller FSM and the line buffers.
- Per-word write masking.
- Registered single-cycle read with a valid strobe.
- Valid/ready request handshake.
- A hardware init/clear sweep that replaces the per-entry reset, so each way's storage can map to single-port SRAM.

Parameters:
NUM_WAYS, 2, ways per set; power of two, 1..8
NUM_SETS, 1024, sets per way; power of two
LINE_BITS, 128, data bits per line
WORD_BITS, 32, write-mask granularity; LINE_BITS must be a multiple of it

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  array accepts a request this cycle
req_we  input  1  1 = write, 0 = read
req_index  input  log2(NUM_SETS)  set index
req_way  input  log2(NUM_WAYS) (min 1)  way select
req_wmask  input  LINE_BITS/WORD_BITS  per-word write enable
req_wdata  input  LINE_BITS  write line
rsp_valid  output  1  read data valid (reads only)
rsp_rdata  output  LINE_BITS  read line
clear_req  input  1  pulse: zero the entire array
init_done  output  1  high once a sweep has completed and no sweep is pending

Behaviour:
- Reset is one clock, asynchronous and active-low on resetn. On assertion: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, sweep counter=0, state=INIT.
- The storage arrays themselves are not reset.
- FSM states: INIT, READY.
- INIT:
  - Each cycle, writes zero to every way of set sweep_cnt, then increments sweep_cnt.
  - Takes exactly NUM_SETS cycles.
  - After the write to set NUM_SETS-1, moves to READY, sets init_done=1 and clears sweep_cnt.
  - req_ready=0 throughout INIT.
- READY: req_ready=1. A request is accepted when req_valid && req_ready.
- Write accept:
  - For each word w with req_wmask[w]=1, set[req_index].way[req_way].word[w] is updated from req_wdata at that edge.
  - Unmasked words are unchanged.
  - No response; rsp_valid stays 0 the following cycle.
  - wmask=0 is a legal no-op.
- Read accept:
  - The following cycle has rsp_valid=1, and rsp_rdata = the line content as of the accept edge.
  - Latency is exactly 1.
  - rsp_valid is a single-cycle pulse per read.
  - rsp_rdata holds its last value when rsp_valid=0.
- Back-to-back: one request per cycle, full throughput.
  - A read that directly follows a write to the same set/way returns the merged, post-write data.
- clear_req:
  - Sampled every cycle. In READY it takes priority over a same-cycle request: that request is not accepted, because req_ready drops combinationally when clear_req=1.
  - Next state is INIT and init_done drops to 0 the next cycle.
  - A read accepted in the previous cycle still delivers its rsp_valid.
  - clear_req asserted during INIT restarts the sweep at set 0.
- resetn asserted mid-sweep or mid-read: immediately returns to the reset values, and the sweep restarts from set 0 after deassertion. A pending rsp_valid is dropped.
- Width rules: req_index and req_way are used directly, with no bounds checks, because the sizes are powers of two.
  - With NUM_WAYS=1, req_way is 1 bit and ignored.
- req_ready is 0 in INIT and 0 in READY whenever clear_req=1; otherwise 1.
- Assertions:
  - Elaboration checks: LINE_BITS % WORD_BITS == 0, and NUM_SETS and NUM_WAYS are powers of two.
  - Runtime check: req_* are known (not X) whenever req_valid=1.

Decomposition:
- Package cache_definitions_pkg gains:
  - parametrised-width helpers and defaults: CACHE_NUM_WAYS, CACHE_NUM_SETS, CACHE_LINE_BITS, CACHE_WORD_BITS;
  - the sa_data_state_e enum {INIT, READY};
  - the sa_data_req_t struct (we, index, way, wmask).
- Sub-module sa_cache_way_bank, instantiated NUM_WAYS times:
  - one way, single-port, with per-word write enable and registered read;
  - no reset on storage.
- The top level holds the FSM, sweep counter, way decode and the output mux of the registered way data.

Test Plan:
1. Release reset -> req_ready=0 and init_done=0 for exactly 1024 cycles; then req_ready=1 and init_done=1. A read of set 5 way 1 returns 0 with rsp_valid one cycle after accept.
2. Write set 3 way 0 with wdata=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 and wmask=4'b1111. Then write wdata=all-ones with wmask=4'b0101. Then read -> rsp_rdata=128'h0123_4567_FFFF_FFFF_FEDC_BA98_FFFF_FFFF.
3. Way isolation: write set 7 way 0=A and way 1=B. Reads of way 0 and way 1 on back-to-back cycles -> rsp_valid high for 2 consecutive cycles, returning A then B.
4. Read accepted at cycle t, clear_req asserted at t+1 with req_valid=1 -> rsp_valid at t+1 with the old data; no accept at t+1; init_done=0 from t+2. After NUM_SETS cycles, every set reads 0.
5. resetn pulsed low at sweep_cnt=500 -> outputs go to reset values asynchronously. After release, the full 1024-cycle sweep is repeated before req_ready=1.
6. Parameter sweep with NUM_WAYS=1, NUM_SETS=16, LINE_BITS=64, WORD_BITS=8 -> a 16-cycle init; byte-mask merge checked against a scoreboard model over 2000 random requests.

Source files
------------

// File: rtl/cache_definitions_pkg.sv
// Shared definitions for the set-associative cache data path: default
// geometry, width helpers, data-array FSM states and the request bundle.
package cache_definitions_pkg;

  localparam int CACHE_NUM_WAYS  = 2;
  localparam int CACHE_NUM_SETS  = 1024;
  localparam int CACHE_LINE_BITS = 128;
  localparam int CACHE_WORD_BITS = 32;

  // Select width for n choices; a single choice still gets a 1-bit field.
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  localparam int CACHE_IDX_W   = sel_bits(CACHE_NUM_SETS);
  localparam int CACHE_WAY_W   = sel_bits(CACHE_NUM_WAYS);
  localparam int CACHE_NWORDS  = CACHE_LINE_BITS / CACHE_WORD_BITS;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } sa_data_state_e;

  // Request control fields at the default geometry, as issued by the controller.
  typedef struct packed {
    logic                    we;
    logic [CACHE_IDX_W-1:0]  index;
    logic [CACHE_WAY_W-1:0]  way;
    logic [CACHE_NWORDS-1:0] wmask;
  } sa_data_req_t;

endpackage

// File: rtl/sa_cache_way_bank.sv
// One way of the data array: single-port storage with per-word write enable
// and a registered read port. Storage is never reset; only the read register is.
module sa_cache_way_bank #(
  parameter int NUM_SETS  = 1024,
  parameter int LINE_BITS = 128,
  parameter int WORD_BITS = 32
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           we,
  input  logic                           re,
  input  logic [$clog2(NUM_SETS)-1:0]    addr,
  input  logic [LINE_BITS/WORD_BITS-1:0] wmask,
  input  logic [LINE_BITS-1:0]           wdata,
  output logic [LINE_BITS-1:0]           rdata
);

  localparam int NWORDS = LINE_BITS / WORD_BITS;

  logic [LINE_BITS-1:0] mem [NUM_SETS];
  logic [LINE_BITS-1:0] rdata_d, rdata_q;

  // Word-granular write into the addressed line; unmasked words keep their value.
  always_ff @(posedge clk) begin
    for (int w = 0; w < NWORDS; w++) begin
      if (we && wmask[w]) begin
        mem[addr][w*WORD_BITS +: WORD_BITS] <= wdata[w*WORD_BITS +: WORD_BITS];
      end
    end
  end

  // Read register loads only on a read so the last line stays visible.
  always_comb begin
    rdata_d = re ? mem[addr] : rdata_q;
  end

  // Read data register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sa_cache_data.sv
// N-way set-associative cache data array. Holds the init/clear sweep FSM,
// the way decode for requests and the output mux over the per-way read
// registers. The sweep zeroes all ways of one set per cycle.
module sa_cache_data
  import cache_definitions_pkg::*;
#(
  parameter int NUM_WAYS  = CACHE_NUM_WAYS,
  parameter int NUM_SETS  = CACHE_NUM_SETS,
  parameter int LINE_BITS = CACHE_LINE_BITS,
  parameter int WORD_BITS = CACHE_WORD_BITS
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [$clog2(NUM_SETS)-1:0]    req_index,
  input  logic [sel_bits(NUM_WAYS)-1:0]  req_way,
  input  logic [LINE_BITS/WORD_BITS-1:0] req_wmask,
  input  logic [LINE_BITS-1:0]           req_wdata,
  output logic                           rsp_valid,
  output logic [LINE_BITS-1:0]           rsp_rdata,
  input  logic                           clear_req,
  output logic                           init_done
);

  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = sel_bits(NUM_WAYS);
  localparam int NWORDS = LINE_BITS / WORD_BITS;
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

  if (LINE_BITS % WORD_BITS != 0) begin : g_bad_word
    $error("LINE_BITS must be a multiple of WORD_BITS");
  end
  if (!is_pow2(NUM_SETS) || !is_pow2(NUM_WAYS)) begin : g_bad_geom
    $error("NUM_SETS and NUM_WAYS must be powers of two");
  end

  sa_data_state_e       state_d, state_q;
  logic [IDX_W-1:0]     sweep_d, sweep_q;
  logic                 init_done_d, init_done_q;
  logic                 rsp_valid_d, rsp_valid_q;
  logic [WAY_W-1:0]     way_sel_d, way_sel_q;
  logic                 accept;

  logic [NUM_WAYS-1:0]  bank_we, bank_re;
  logic [IDX_W-1:0]     bank_addr;
  logic [NWORDS-1:0]    bank_wmask;
  logic [LINE_BITS-1:0] bank_wdata;
  logic [LINE_BITS-1:0] bank_rd [NUM_WAYS];

  // Handshake: a clear request blocks acceptance in the same cycle.
  always_comb begin
    req_ready = (state_q == READY) && !clear_req;
    accept    = req_valid && req_ready;
  end

  // Sweep/next-state logic and read-response tracking.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    init_done_d = init_done_q;
    case (state_q)
      INIT: begin
        if (clear_req) begin
          sweep_d = '0;
        end else if (sweep_q == LAST_SET) begin
          state_d     = READY;
          init_done_d = 1'b1;
          sweep_d     = '0;
        end else begin
          sweep_d = sweep_q + IDX_W'(1);
        end
      end
      READY: begin
        if (clear_req) begin
          state_d     = INIT;
          init_done_d = 1'b0;
        end
      end
      default: state_d = INIT;
    endcase
    rsp_valid_d = accept && !req_we;
    way_sel_d   = (accept && !req_we) ? req_way : way_sel_q;
  end

  // Bank port steering: the sweep writes zero to every way, otherwise decode req_way.
  always_comb begin
    bank_addr  = (state_q == INIT) ? sweep_q : req_index;
    bank_wmask = (state_q == INIT) ? '1 : req_wmask;
    bank_wdata = (state_q == INIT) ? '0 : req_wdata;
    for (int i = 0; i < NUM_WAYS; i++) begin
      bank_we[i] = (state_q == INIT) ||
                   (accept && req_we && ((NUM_WAYS == 1) || (req_way == WAY_W'(i))));
      bank_re[i] = accept && !req_we && ((NUM_WAYS == 1) || (req_way == WAY_W'(i)));
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      way_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      way_sel_q   <= way_sel_d;
    end
  end

  for (genvar i = 0; i < NUM_WAYS; i++) begin : g_way
    sa_cache_way_bank #(
      .NUM_SETS  (NUM_SETS),
      .LINE_BITS (LINE_BITS),
      .WORD_BITS (WORD_BITS)
    ) u_bank (
      .clk    (clk),
      .resetn (resetn),
      .we     (bank_we[i]),
      .re     (bank_re[i]),
      .addr   (bank_addr),
      .wmask  (bank_wmask),
      .wdata  (bank_wdata),
      .rdata  (bank_rd[i])
    );
  end

  if (NUM_WAYS == 1) begin : g_mux1
    assign rsp_rdata = bank_rd[0];
  end else begin : g_muxn
    assign rsp_rdata = bank_rd[way_sel_q];
  end

  assign rsp_valid = rsp_valid_q;
  assign init_done = init_done_q;

  a_req_known: assert property (@(posedge clk) disable iff (!resetn)
    req_valid |-> !$isunknown({req_we, req_index, req_way, req_wmask, req_wdata}));

endmodule

// File: tb/tb_sa_cache_data.sv
// Bench for sa_cache_data: default geometry instance checked every cycle
// against a behavioural model, plus a small single-way byte-mask instance
// driven with random traffic against a scoreboard.
module tb_sa_cache_data;

  localparam int NS = 1024;
  localparam int NWY = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: default geometry
  logic         resetn = 1'b0;
  logic         req_valid = 1'b0, req_we = 1'b0, clear_req = 1'b0;
  logic [9:0]   req_index = '0;
  logic [0:0]   req_way = '0;
  logic [3:0]   req_wmask = '0;
  logic [127:0] req_wdata = '0;
  logic         req_ready, rsp_valid, init_done;
  logic [127:0] rsp_rdata;

  sa_cache_data #(.NUM_WAYS(2), .NUM_SETS(1024), .LINE_BITS(128), .WORD_BITS(32)) u_dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_index(req_index), .req_way(req_way), .req_wmask(req_wmask),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .clear_req(clear_req), .init_done(init_done)
  );

  // Instance B: one way, 16 sets, 64-bit lines, byte mask
  logic         resetn_b = 1'b0;
  logic         req_valid_b = 1'b0, req_we_b = 1'b0, clear_req_b = 1'b0;
  logic [3:0]   req_index_b = '0;
  logic [0:0]   req_way_b = '0;
  logic [7:0]   req_wmask_b = '0;
  logic [63:0]  req_wdata_b = '0;
  logic         req_ready_b, rsp_valid_b, init_done_b;
  logic [63:0]  rsp_rdata_b;

  sa_cache_data #(.NUM_WAYS(1), .NUM_SETS(16), .LINE_BITS(64), .WORD_BITS(8)) u_dut_b (
    .clk(clk), .resetn(resetn_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_we(req_we_b), .req_index(req_index_b), .req_way(req_way_b), .req_wmask(req_wmask_b),
    .req_wdata(req_wdata_b), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .clear_req(clear_req_b), .init_done(init_done_b)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Behavioural model of instance A: cycles left until the array is usable,
  // the line contents, and the expected response registers.
  int           m_left;
  logic         m_rv;
  logic [127:0] m_rd;
  logic [127:0] m_mem [NWY][NS];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_left <= NS;
      m_rv   <= 1'b0;
      m_rd   <= '0;
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < NWY; w++) m_mem[w][s] <= '0;
    end else begin
      m_rv <= 1'b0;
      if (m_left == 0 && !clear_req && req_valid) begin
        if (req_we) begin
          for (int k = 0; k < 4; k++)
            if (req_wmask[k]) m_mem[req_way][req_index][k*32 +: 32] <= req_wdata[k*32 +: 32];
        end else begin
          m_rv <= 1'b1;
          m_rd <= m_mem[req_way][req_index];
        end
      end
      if (clear_req) begin
        m_left <= NS;
        for (int s = 0; s < NS; s++)
          for (int w = 0; w < NWY; w++) m_mem[w][s] <= '0;
      end else if (m_left != 0) begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("a_ready", req_ready, (m_left == 0) && !clear_req);
    chk("a_init_done", init_done, m_left == 0);
    chk("a_rsp_valid", rsp_valid, m_rv);
    chk("a_rsp_rdata", rsp_rdata, m_rd);
  end

  task automatic req(input logic we, input int idx, input int way,
                     input logic [3:0] m, input logic [127:0] d);
    @(posedge clk); #2;
    req_valid = 1'b1; req_we = we; req_index = 10'(idx); req_way = 1'(way);
    req_wmask = m; req_wdata = d;
  endtask

  task automatic idle();
    @(posedge clk); #2;
    req_valid = 1'b0; clear_req = 1'b0;
  endtask

  // Caller sits at a negedge; counts negedges with req_ready low.
  task automatic wait_ready(input string nm, input int exp_cycles);
    int n = 0;
    while (!req_ready && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk(nm, n, exp_cycles);
  endtask

  localparam logic [127:0] VA = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] VB = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] sb [16];
    logic        prev_rd, cur_rd;
    logic [63:0] prev_exp, cur_exp, last_b;
    int          n;

    // 1: reset release, full sweep, read of a cleared line
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    chk("t1_ready_low", req_ready, 1'b0);
    chk("t1_done_low", init_done, 1'b0);
    wait_ready("t1_init_cycles", 1024);
    chk("t1_done_high", init_done, 1'b1);
    req(1'b0, 5, 1, 4'h0, '0);
    idle();
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rsp_zero", rsp_rdata, 128'h0);

    // 2: word-mask merge
    req(1'b1, 3, 0, 4'b1111, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    req(1'b1, 3, 0, 4'b0101, {128{1'b1}});
    req(1'b0, 3, 0, 4'h0, '0);
    idle();
    @(negedge clk);
    chk("t2_merge_valid", rsp_valid, 1'b1);
    chk("t2_merge_data", rsp_rdata, 128'h0123_4567_FFFF_FFFF_FEDC_BA98_FFFF_FFFF);
    req(1'b1, 3, 0, 4'b0000, 128'h0);
    req(1'b0, 3, 0, 4'h0, '0);
    idle();
    @(negedge clk);
    chk("t2_nomask_data", rsp_rdata, 128'h0123_4567_FFFF_FFFF_FEDC_BA98_FFFF_FFFF);

    // 3: way isolation, back-to-back reads
    req(1'b1, 7, 0, 4'hF, VA);
    req(1'b1, 7, 1, 4'hF, VB);
    req(1'b0, 7, 0, 4'h0, '0);
    req(1'b0, 7, 1, 4'h0, '0);
    @(negedge clk);
    chk("t3_rv_way0", rsp_valid, 1'b1);
    chk("t3_rd_way0", rsp_rdata, VA);
    idle();
    @(negedge clk);
    chk("t3_rv_way1", rsp_valid, 1'b1);
    chk("t3_rd_way1", rsp_rdata, VB);
    @(negedge clk);
    chk("t3_rv_pulse", rsp_valid, 1'b0);

    // 4: clear right after a read accept
    req(1'b0, 7, 1, 4'h0, '0);
    @(posedge clk); #2;
    clear_req = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_index = 10'd7; req_way = 1'b0;
    @(negedge clk);
    chk("t4_ready_blocked", req_ready, 1'b0);
    chk("t4_old_rv", rsp_valid, 1'b1);
    chk("t4_old_rd", rsp_rdata, VB);
    idle();
    @(negedge clk);
    chk("t4_done_drop", init_done, 1'b0);
    chk("t4_no_accept", rsp_valid, 1'b0);
    wait_ready("t4_init_cycles", 1024);
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NWY; w++) req(1'b0, s, w, 4'h0, '0);
    idle();
    req(1'b0, 3, 0, 4'h0, '0);
    idle();
    @(negedge clk);
    chk("t4_cleared_rd", rsp_rdata, 128'h0);

    // 5: reset mid-sweep
    req(1'b1, 9, 1, 4'hF, VA);
    req(1'b0, 9, 1, 4'h0, '0);
    idle();
    @(negedge clk);
    chk("t5_pre_rd", rsp_rdata, VA);
    @(posedge clk); #2 clear_req = 1'b1;
    @(posedge clk); #2 clear_req = 1'b0;
    repeat (500) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("t5_async_ready", req_ready, 1'b0);
    chk("t5_async_done", init_done, 1'b0);
    chk("t5_async_rv", rsp_valid, 1'b0);
    chk("t5_async_rd", rsp_rdata, 128'h0);
    @(posedge clk); #2 resetn = 1'b1;
    @(negedge clk);
    wait_ready("t5_init_cycles", 1024);

    // 6: single-way byte-mask instance, random traffic vs scoreboard
    @(posedge clk); #2 resetn_b = 1'b1;
    @(negedge clk);
    n = 0;
    while (!req_ready_b && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("t6_init_cycles", n, 16);
    chk("t6_done", init_done_b, 1'b1);
    for (int s = 0; s < 16; s++) sb[s] = '0;
    prev_rd = 1'b0; prev_exp = '0; last_b = '0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      req_valid_b = ($urandom % 8) != 0;
      req_we_b    = 1'($urandom);
      req_index_b = 4'($urandom);
      req_way_b   = 1'($urandom);
      req_wmask_b = 8'($urandom);
      req_wdata_b = {$urandom, $urandom};
      cur_rd  = req_valid_b && !req_we_b;
      cur_exp = sb[req_index_b];
      if (req_valid_b && req_we_b)
        for (int k = 0; k < 8; k++)
          if (req_wmask_b[k]) sb[req_index_b][k*8 +: 8] = req_wdata_b[k*8 +: 8];
      @(negedge clk);
      chk("t6_ready", req_ready_b, 1'b1);
      chk("t6_rsp_valid", rsp_valid_b, prev_rd);
      if (prev_rd) last_b = prev_exp;
      chk("t6_rsp_rdata", rsp_rdata_b, last_b);
      prev_rd  = cur_rd;
      prev_exp = cur_exp;
    end
    @(posedge clk); #2 req_valid_b = 1'b0;
    @(negedge clk);
    chk("t6_last_valid", rsp_valid_b, prev_rd);
    if (prev_rd) last_b = prev_exp;
    chk("t6_last_rdata", rsp_rdata_b, last_b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
